// File: rtl/cnt_timer_ctrl.sv
// cnt_timer_ctrl: turns a programmed period into a counter preload and issues one-shot or periodic expiry ticks.
// Optional macro CNT_TIMER_CTRL_TICK_COUNT_EN adds a saturating tick_count output.
module cnt_timer_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_period,
  output logic             cfg_ready,
  input  logic             mode_periodic,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_data_load,
  output logic             tick,
  output logic             busy,
  output logic             err
`ifdef CNT_TIMER_CTRL_TICK_COUNT_EN
  ,
  output logic [15:0]      tick_count
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  logic [1:0]       state, state_nx;
  logic [WIDTH-1:0] period_q;
  logic             mode_q, err_q, cfg_hs, go, expiry;
  assign cfg_ready     = state == IDLE;
  assign busy          = state != IDLE;
  assign cfg_hs        = cfg_valid && cfg_ready;
  assign go            = cfg_ready && start && period_q != '0;
  assign expiry        = state == RUN && cnt_in == '1;
  assign tick          = expiry;
  assign err           = err_q;
  // Counting up from 2^WIDTH - period reaches all ones after exactly period cycles.
  assign cnt_data_load = {WIDTH{1'b0}} - period_q;
  assign cnt_load      = state == LOAD || (expiry && mode_q && !stop);
  always_comb begin
    state_nx = state == IDLE ? (go ? LOAD : IDLE) :
               state == LOAD ? (stop ? IDLE : RUN) :
               state == RUN  ? ((stop || (expiry && !mode_q)) ? IDLE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      period_q <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (cfg_hs && cfg_period != '0) period_q <= cfg_period;
      if (go) mode_q <= mode_periodic;
      err_q <= (cfg_hs && cfg_period == '0) || (cfg_ready && start && period_q == '0);
    end
  end
`ifdef CNT_TIMER_CTRL_TICK_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_count <= '0;
    else if (go) tick_count <= '0;
    else if (tick && tick_count != 16'hFFFF) tick_count <= tick_count + 16'd1;
  end
`endif
endmodule
